rot_pixel_packer: RTL and testbench

- Downstream consumer of the SRAM rotate adapter's read phase.
- Accepts the rotated 8-bit pixel stream, one pixel per cycle, plus its line-start and frame-done markers.
- Packs 4 pixels into 32-bit words and buffers them in a FIFO, because the adapter cannot stall.
- Presents the words on a valid/ready master interface with line-start and end-of-frame sideband flags.

---
 rtl/rot_pixel_packer_if.sv | 12 +
 rtl/rot_pixel_packer.sv | 143 ++++++++++++++
 tb/tb_rot_pixel_packer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rot_pixel_packer_if.sv
// Packed-word stream from rot_pixel_packer: 32-bit data plus line-start and
// end-of-frame sideband, valid/ready handshake.
interface rot_pixel_packer_if;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_sol;
  logic        m_last;

  modport master (output m_data, m_valid, m_sol, m_last, input m_ready);
  modport slave  (input m_data, m_valid, m_sol, m_last, output m_ready);
endinterface

// File: rtl/rot_pixel_packer.sv
// Packs the rotated 8-bit pixel stream into 32-bit words behind a FWFT FIFO.
// Optional PACK_STATS_EN adds FIFO high-water mark and drop counter outputs.
module rot_pixel_packer #(
  parameter int IMG_W      = 1024,
  parameter int IMG_H      = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            pix_in,
  input  logic                  sol_in,
  input  logic                  eof_in,
  rot_pixel_packer_if.master    m,
  output logic                  overflow,
  output logic                  align_err,
  output logic                  frame_done
`ifdef PACK_STATS_EN
  ,
  output logic [LVL_W-1:0]      max_level,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int LINE_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_H - 1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

  logic [1:0]        lane_p0;
  logic [COL_W-1:0]  col_p0;
  logic [LINE_W-1:0] line_p0;
  logic [7:0]        sr_p0 [3];
  logic              fin_p1;

  logic              resync, col_wrap, at_final, eof_bad;
  logic [1:0]        lane_eff;
  logic [COL_W-1:0]  col_eff;
  logic              push_req, push_sol, push_last;
  logic [31:0]       push_data;

  // Stage p0: a mid-line sol_in restarts the line, so the current pixel is col 0
  always_comb begin
    resync    = in_valid && sol_in && (col_p0 != '0);
    lane_eff  = resync ? 2'd0 : lane_p0;
    col_eff   = resync ? '0 : col_p0;
    col_wrap  = (col_eff == COL_LAST);
    at_final  = (line_p0 == LINE_LAST) && (col_p0 == COL_LAST);
    eof_bad   = eof_in && !at_final && !fin_p1;
    push_req  = in_valid && (lane_eff == 2'd3);
    push_data = {pix_in, sr_p0[2], sr_p0[1], sr_p0[0]};
    push_sol  = (col_eff == COL_W'(3));
    push_last = (line_p0 == LINE_LAST) && col_wrap;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_p0   <= '0;
      col_p0    <= '0;
      line_p0   <= '0;
      fin_p1    <= 1'b0;
      align_err <= 1'b0;
    end else begin
      fin_p1 <= in_valid && push_last;
      if (resync || eof_bad) align_err <= 1'b1;
      if (in_valid) begin
        lane_p0 <= lane_eff + 2'd1;
        col_p0  <= col_wrap ? '0 : col_eff + COL_W'(1);
        if (col_wrap) line_p0 <= (line_p0 == LINE_LAST) ? '0 : line_p0 + LINE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && (lane_eff != 2'd3)) sr_p0[lane_eff] <= pix_in;
  end

  // Stage p1: word FIFO, first-word-fall-through, entry = {last, sol, data}
  logic [33:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level, level_nxt;
  logic              valid, full, pop, push, drop;
  logic [33:0]       head;

  always_comb begin
    valid = (level != '0);
    full  = (level == LVL_FULL);
    pop   = valid && m.m_ready;
    push  = push_req && (!full || pop);
    drop  = push_req && full && !pop;
    head  = mem[rd_ptr];
    case ({push, pop})
      2'b10:   level_nxt = level + LVL_W'(1);
      2'b01:   level_nxt = level - LVL_W'(1);
      default: level_nxt = level;
    endcase
  end

  assign m.m_valid = valid;
  assign m.m_data  = valid ? head[31:0] : '0;
  assign m.m_sol   = valid && head[32];
  assign m.m_last  = valid && head[33];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level      <= level_nxt;
      frame_done <= pop && head[33];
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_sol, push_data};
  end

`ifdef PACK_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_level <= '0;
      drop_cnt  <= '0;
    end else begin
      if (level_nxt > max_level) max_level <= level_nxt;
      if (drop) drop_cnt <= sat_inc16(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_rot_pixel_packer.sv
// Randomized bench for rot_pixel_packer against a pixel-position / word-queue model.
module tb_rot_pixel_packer;
  localparam int W = 8;
  localparam int H = 2;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] pix_in = 8'h00;
  logic       sol_in = 1'b0;
  logic       eof_in = 1'b0;
  logic       overflow, align_err, frame_done;
`ifdef PACK_STATS_EN
  logic [4:0]  max_level;
  logic [15:0] drop_cnt;
`endif

  rot_pixel_packer_if bus ();

  rot_pixel_packer #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D), .LVL_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .pix_in     (pix_in),
    .sol_in     (sol_in),
    .eof_in     (eof_in),
    .m          (bus),
    .overflow   (overflow),
    .align_err  (align_err),
    .frame_done (frame_done)
`ifdef PACK_STATS_EN
    ,
    .max_level  (max_level),
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model: absolute pixel position in the frame, the partial word, and FIFO contents.
  logic [33:0] mq[$];
  logic [7:0]  mpart[$];
  int          mpos;
  bit          m_ovf, m_err, m_fd, mfin;
  int          total, bad, cyc;
  bit          hs, hs_last, hs_sol;
  int          hs_cyc;

  function automatic logic [37:0] model_vec();
    logic [33:0] h;
    h = (mq.size() != 0) ? mq[0] : 34'h0;
    return {mq.size() != 0, h, m_ovf, m_err, m_fd};
  endfunction

  function automatic logic [37:0] dut_vec();
    return {bus.m_valid, bus.m_last, bus.m_sol, bus.m_data, overflow, align_err, frame_done};
  endfunction

  task automatic model_reset();
    mq.delete(); mpart.delete();
    mpos = 0; m_ovf = 0; m_err = 0; m_fd = 0; mfin = 0;
  endtask

  function automatic logic [7:0] rnd();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic tick(input bit v, input logic [7:0] p, input bit s, input bit e);
    bit pop, have_push, fd_n;
    logic [33:0] w;
    in_valid = v; pix_in = p; sol_in = s; eof_in = e;
    @(negedge clk);
    hs = bus.m_valid && bus.m_ready; hs_last = bus.m_last; hs_sol = bus.m_sol; hs_cyc = cyc;
    pop = (mq.size() != 0) && bus.m_ready;
    fd_n = pop ? mq[0][33] : 1'b0;
    have_push = 0; w = '0;
    if (e && (mpos != W*H-1) && !mfin) m_err = 1;
    mfin = 0;
    if (v) begin
      if (s && (mpos % W) != 0) begin
        m_err = 1; mpart.delete(); mpos -= mpos % W;
      end
      mpart.push_back(p);
      if (mpart.size() == 4) begin
        w = {mpos == W*H-1, (mpos % W) == 3, mpart[3], mpart[2], mpart[1], mpart[0]};
        have_push = 1; mpart.delete();
      end
      mfin = (mpos == W*H-1);
      mpos = (mpos + 1) % (W*H);
    end
    if (pop) void'(mq.pop_front());
    if (have_push) begin
      if (mq.size() < D) mq.push_back(w);
      else m_ovf = 1;
    end
    m_fd = fd_n;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dut_vec() !== 38'h0) begin bad++; $display("FAIL reset_hold got=%h want=0", dut_vec()); end
    @(negedge clk); rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    tick(0, 8'h00, 0, 0);
    total++;
    if (dut_vec() !== model_vec()) begin bad++; $display("FAIL reset_idle got=%h want=%h", dut_vec(), model_vec()); end
  endtask

  task automatic test_basic();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1, 8'(i), i == 0, 0);
      total++;
      if (dut_vec() !== model_vec()) begin bad++; $display("FAIL basic cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec()); end
      if (i == 2) begin
        total++;
        if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b want=0", bus.m_valid); end
      end
      if (i == 3) begin
        total++;
        if ({bus.m_valid, bus.m_sol, bus.m_data} !== {2'b11, 32'h03020100}) begin
          bad++; $display("FAIL basic_word0 got=%b%b_%h want=11_03020100", bus.m_valid, bus.m_sol, bus.m_data);
        end
      end
      if (i == 7) begin
        total++;
        if ({bus.m_valid, bus.m_sol, bus.m_data} !== {2'b10, 32'h07060504}) begin
          bad++; $display("FAIL basic_word1 got=%b%b_%h want=10_07060504", bus.m_valid, bus.m_sol, bus.m_data);
        end
      end
    end
    tick(0, 8'h00, 0, 0);
    total++;
    if (dut_vec() !== model_vec()) begin bad++; $display("FAIL basic_drain got=%h want=%h", dut_vec(), model_vec()); end
  endtask

  task automatic test_full_pop();
    int n;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 68; i++) begin
      if (i == 67) bus.m_ready = 1'b1;
      tick(1, rnd(), (mpos % W) == 0, 0);
      total++;
      if (dut_vec() !== model_vec()) begin bad++; $display("FAIL fullpop_fill cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec()); end
    end
    bus.m_ready = 1'b0;
    total++;
    if ({bus.m_valid, overflow} !== 2'b10) begin bad++; $display("FAIL fullpop_ovf got=%b%b want=10", bus.m_valid, overflow); end
    bus.m_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick(0, 8'h00, 0, 0);
      if (hs) n++;
      total++;
      if (dut_vec() !== model_vec()) begin bad++; $display("FAIL fullpop_drain cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec()); end
    end
    total++;
    if (n !== 16) begin bad++; $display("FAIL fullpop_count got=%0d want=16", n); end
  endtask

  task automatic test_overflow();
    int n, first, last;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 68; i++) begin
      tick(1, rnd(), (mpos % W) == 0, 0);
      total++;
      if (dut_vec() !== model_vec()) begin bad++; $display("FAIL ovf_fill cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec()); end
      if (i == 63) begin
        total++;
        if ({bus.m_valid, overflow} !== 2'b10) begin bad++; $display("FAIL ovf_at_full got=%b%b want=10", bus.m_valid, overflow); end
      end
    end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
    bus.m_ready = 1'b1;
    n = 0; first = -1; last = -1;
    for (int k = 0; k < 20; k++) begin
      tick(0, 8'h00, 0, 0);
      if (hs) begin
        n++;
        if (first < 0) first = hs_cyc;
        last = hs_cyc;
      end
      total++;
      if (dut_vec() !== model_vec()) begin bad++; $display("FAIL ovf_drain cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec()); end
    end
    total++;
    if (n !== 16 || last - first !== 15) begin bad++; $display("FAIL ovf_burst got=%0d/%0d want=16/15", n, last - first); end
  endtask

  task automatic test_sol_resync();
    logic [7:0] p, q0, q1, q2;
    bus.m_ready = 1'b1;
    for (int g = 0; g < W && (mpos % W) != 0; g++) tick(1, rnd(), 0, 0);
    tick(1, rnd(), 1, 0);
    tick(1, rnd(), 0, 0);
    p = rnd();
    tick(1, p, 1, 0);
    total++;
    if (align_err !== 1'b1) begin bad++; $display("FAIL resync_err got=%b want=1", align_err); end
    q0 = rnd(); q1 = rnd(); q2 = rnd();
    tick(1, q0, 0, 0);
    tick(1, q1, 0, 0);
    tick(1, q2, 0, 0);
    total++;
    if ({bus.m_valid, bus.m_sol, bus.m_data} !== {2'b11, q2, q1, q0, p}) begin
      bad++; $display("FAIL resync_word got=%b%b_%h want=11_%h", bus.m_valid, bus.m_sol, bus.m_data, {q2, q1, q0, p});
    end
    total++;
    if (dut_vec() !== model_vec()) begin bad++; $display("FAIL resync_model got=%h want=%h", dut_vec(), model_vec()); end
    for (int k = 0; k < 4; k++) begin
      tick(1, rnd(), (mpos % W) == 0, 0);
      total++;
      if (dut_vec() !== model_vec()) begin bad++; $display("FAIL resync_tail cyc=%0d got=%h want=%h", cyc, dut_vec(), model_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 9; i++) tick(1, rnd(), (mpos % W) == 0, 0);
    total++;
    if (dut_vec() !== model_vec()) begin bad++; $display("FAIL rstmid_pre got=%h want=%h", dut_vec(), model_vec()); end
    in_valid = 1'b0;
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 38'h0) begin bad++; $display("FAIL rstmid_async got=%h want=0", dut_vec()); end
    model_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick(1, rnd(), i == 0, 0);
    total++;
    if ({bus.m_valid, bus.m_sol} !== 2'b11) begin bad++; $display("FAIL rstmid_sol got=%b%b want=11", bus.m_valid, bus.m_sol); end
    total++;
    if (dut_vec() !== model_vec()) begin bad++; $display("FAIL rstmid_word got=%h want=%h", dut_vec(), model_vec()); end
  endtask

  task automatic test_frame();
    logic [1:0] flags[$];
    int fd_cnt, fd_cyc, last_cyc;
    bus.m_ready = 1'b1;
    for (int g = 0; g < W*H && mpos != 0; g++) tick(1, rnd(), (mpos % W) == 0, 0);
    tick(0, 8'h00, 0, 0);
    for (int f = 0; f < 2; f++) begin
      flags.delete(); fd_cnt = 0; fd_cyc = -1; last_cyc = -100;
      for (int i = 0; i < W*H + 4; i++) begin
        if (i < W*H) tick(1, rnd(), (i % W) == 0, f == 1 && i == W*H-1);
        else         tick(0, 8'h00, 0, f == 0 && i == W*H);
        if (hs) begin
          flags.push_back({hs_sol, hs_last});
          if (hs_last) last_cyc = hs_cyc;
        end
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        total++;
        if (dut_vec() !== model_vec()) begin bad++; $display("FAIL frame%0d cyc=%0d got=%h want=%h", f, cyc, dut_vec(), model_vec()); end
      end
      total++;
      if (flags.size() != 4 || flags[0] !== 2'b10 || flags[1] !== 2'b00 || flags[2] !== 2'b10 || flags[3] !== 2'b01) begin
        bad++; $display("FAIL frame%0d_flags got=%p want=10,00,10,01", f, flags);
      end
      total++;
      if (fd_cnt !== 1 || fd_cyc !== last_cyc + 1) begin
        bad++; $display("FAIL frame%0d_done got=cnt%0d@%0d want=cnt1@%0d", f, fd_cnt, fd_cyc, last_cyc + 1);
      end
      total++;
      if (align_err !== 1'b0) begin bad++; $display("FAIL frame%0d_eof_ok got=%b want=0", f, align_err); end
    end
    tick(1, rnd(), 1, 1);
    total++;
    if (align_err !== 1'b1) begin bad++; $display("FAIL eof_misplaced got=%b want=1", align_err); end
    total++;
    if (dut_vec() !== model_vec()) begin bad++; $display("FAIL eof_model got=%h want=%h", dut_vec(), model_vec()); end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    bus.m_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_full_pop();
    test_overflow();
    test_sol_resync();
    test_reset_mid();
    test_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
